updi_cmd_gen: RTL and testbench
===============================

Name: updi_cmd_gen

Overview:
Parametrised UPDI command generator and the successor to the single-format command FSM. It accepts one command descriptor per transaction: LDCS, STCS, LDS, STS, or a block-write burst. It expands the descriptor into the complete UPDI frame sequence: SYNCH bytes, opcodes, address bytes, REPEAT prefix and payload. It then presents each byte as a parity-framed UART word to the downstream serializer over a valid/ready stream.

Parameters:
ADDR_BYTES, 2, address length in bytes; 2 or 3; selects the opcode address-size field (2→01, 3→10).
STOP_BITS, 2, stop bits per frame; 1 or 2; localparam FRAME_W = 10 + STOP_BITS.

Ports:
i_clk  in  1  clock
i_rstn  in  1  asynchronous active-low reset
i_cmd_valid  in  1  command descriptor valid
o_cmd_ready  out  1  high only in IDLE
i_cmd_op  in  3  0 LDCS, 1 STCS, 2 LDS, 3 STS, 4 BURST; 5-7 illegal
i_cmd_cs  in  4  control/status register index (LDCS/STCS)
i_cmd_addr  in  8*ADDR_BYTES  target address (LDS/STS/BURST)
i_cmd_len  in  8  BURST byte count minus 1
i_wdata  in  8  write payload byte
i_wdata_valid  in  1  payload valid
o_wdata_ready  out  1  payload byte accepted this cycle when high with valid
o_frame  out  FRAME_W  {start 0, byte[7:0], even parity, STOP_BITS ones}
o_frame_valid  out  1  frame valid
i_frame_ready  in  1  serializer accepts frame
i_abort  in  1  synchronous abort request
o_rx_expect  out  1  pulse with o_cmd_done for LDCS/LDS: one response byte follows
o_cmd_done  out  1  one-cycle pulse when the last frame of a command is accepted
o_cmd_err  out  1  one-cycle pulse on illegal op or abort

Behaviour:
- Reset (async, i_rstn=0): state IDLE. All outputs low except o_cmd_ready=1. o_frame=0.
- Descriptor capture: i_cmd_valid&o_cmd_ready latches op/cs/addr/len. The first frame is valid the next cycle.
- Illegal op: no frames issued. o_cmd_err pulses the next cycle. Block stays in IDLE.
- Register CS data: RSD=1 on target, so no ACK frames are awaited.
- Frame sequences (addr bytes LSB first; AS = address-size code):
  - LDCS: 55, 80|cs
  - STCS: 55, C0|cs, D
  - LDS: 55, 00|AS<<2, addr
  - STS: 55, 40|AS<<2, addr, D
  - BURST: 55, 68|AS, addr, 55, A0, len, 55, 64, D×(len+1)
- States: IDLE, SYNC, OPCODE, ADDR, RPT_OP, RPT_CNT, DATA. A registered step field selects the opcode and the post-SYNC target.
- Output register: single entry. Loads when empty or when being accepted in the same cycle, which gives full throughput of one frame per clock. o_frame is stable while o_frame_valid&!i_frame_ready.
- Parity: ^byte (even). Frame packing is MSB-first as listed. Bit ordering on the line is the serializer's job.
- Payload: o_wdata_ready = (state==DATA) & (output register empty | i_frame_ready). The payload byte is framed in the same cycle it is accepted; payload latency is one cycle.
- Counters: address-byte counter width $clog2(ADDR_BYTES). Burst counter is 9 bits, loaded with len+1. i_cmd_len=0 gives 1 byte; i_cmd_len=255 gives 256 bytes.
- o_cmd_done / o_rx_expect: pulse in the cycle after the final frame is accepted. State returns to IDLE in that same cycle, and o_cmd_ready=1.
- i_abort: takes priority in any non-IDLE state.
  - Next cycle: o_frame_valid=0, state IDLE, o_cmd_err pulse; o_cmd_done does not pulse.
  - A frame already accepted is not recalled.
  - In IDLE, i_abort is ignored.
- Simultaneous i_abort and i_cmd_valid in IDLE: the command is accepted.
- Reset mid-command: everything is dropped immediately. No done or err pulse is generated.

Decomposition:
- Package updi_pkg holds:
  - Opcode constants: SYNCH=8'h55, LDCS=8'h80, STCS=8'hC0, LDS=8'h00, STS=8'h40, ST_PTR=8'h68, ST_PTR_INC=8'h64, REPEAT=8'hA0.
  - Enum cmd_op_t.
  - Function updi_frame(byte, stop_bits) returning the packed frame.
- Sub-module updi_frame_reg: the single-entry valid/ready output register with parity packing.

Test Plan:
- Default params; LDCS cs=0xB → frames 0x2AB, 0x45B. Then o_cmd_done and o_rx_expect pulse together, one cycle after the last accept.
- STS addr=0x1234, D=0xA5, i_frame_ready always 1 → 0x2AB, 0x223, 0x1A7, 0x093, 0x52B on consecutive cycles. Then o_cmd_done.
- BURST addr=0x1234, len=3, data 0x01..0x04 → 13 frames: 55, 69, 34, 12, 55, A0, 03, 55, 64, 01, 02, 03, 04. Check exactly 4 wdata handshakes; repeat with len=0 (1 byte) and len=255 (256 bytes).
- Backpressure: drop i_frame_ready for 5 cycles mid-STS → o_frame holds its value. No wdata is accepted while the output is full.
- Illegal op=6 → no o_frame_valid, o_cmd_err pulse. Abort during BURST data byte 2 → o_frame_valid low next cycle, o_cmd_err pulse, IDLE.
- ADDR_BYTES=3, STOP_BITS=1; LDS addr=0x012345 → opcodes 55, 08, then 45, 23, 01 (11-bit frames). Assert i_rstn low mid-sequence → outputs clear asynchronously.

Source files
------------

// File: rtl/updi_pkg.sv
// Shared UPDI opcodes, command/FSM enums and the UART frame packer used by
// the command generator.
package updi_pkg;

    localparam logic [7:0] SYNCH      = 8'h55;
    localparam logic [7:0] LDCS       = 8'h80;
    localparam logic [7:0] STCS       = 8'hC0;
    localparam logic [7:0] LDS        = 8'h00;
    localparam logic [7:0] STS        = 8'h40;
    localparam logic [7:0] ST_PTR     = 8'h68;
    localparam logic [7:0] ST_PTR_INC = 8'h64;
    localparam logic [7:0] REPEAT     = 8'hA0;

    typedef enum logic [2:0] {
        OP_LDCS  = 3'd0,
        OP_STCS  = 3'd1,
        OP_LDS   = 3'd2,
        OP_STS   = 3'd3,
        OP_BURST = 3'd4
    } cmd_op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_OPCODE,
        S_ADDR,
        S_RPT_OP,
        S_RPT_CNT,
        S_DATA
    } state_t;

    // MAIN: first opcode of the command; RPT: SYNC ahead of REPEAT;
    // INC: SYNC/opcode ahead of the ST ptr++ payload.
    typedef enum logic [1:0] {
        STEP_MAIN,
        STEP_RPT,
        STEP_INC
    } step_t;

    // {start 0, data, even parity, stop ones}, right-aligned in 12 bits.
    function automatic logic [11:0] updi_frame(input logic [7:0] data, input int stop_bits);
        if (stop_bits == 1) begin
            return {1'b0, 1'b0, data, ^data, 1'b1};
        end
        return {1'b0, data, ^data, 2'b11};
    endfunction

endpackage

// File: rtl/updi_frame_reg.sv
// Single-entry valid/ready output register; packs each loaded byte into a
// parity-framed UART word.
module updi_frame_reg
    import updi_pkg::*;
#(
    parameter int STOP_BITS = 2,
    parameter int FRAME_W   = 10 + STOP_BITS
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_flush,
    input  logic               i_valid,
    input  logic [7:0]         i_byte,
    output logic               o_ready,
    output logic [FRAME_W-1:0] o_frame,
    output logic               o_valid,
    input  logic               i_ready
);

    // Loading while the held frame drains keeps one frame per clock.
    assign o_ready = !o_valid || i_ready;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_valid <= 1'b0;
            o_frame <= '0;
        end else if (i_flush) begin
            o_valid <= 1'b0;
        end else if (i_valid && o_ready) begin
            o_valid <= 1'b1;
            o_frame <= FRAME_W'(updi_frame(i_byte, STOP_BITS));
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/updi_cmd_gen.sv
// Expands one command descriptor (LDCS/STCS/LDS/STS/BURST) into its UPDI byte
// sequence and streams it as UART frames.
module updi_cmd_gen
    import updi_pkg::*;
#(
    parameter int ADDR_BYTES = 2,
    parameter int STOP_BITS  = 2,
    localparam int FRAME_W   = 10 + STOP_BITS
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    input  logic                    i_cmd_valid,
    output logic                    o_cmd_ready,
    input  logic [2:0]              i_cmd_op,
    input  logic [3:0]              i_cmd_cs,
    input  logic [8*ADDR_BYTES-1:0] i_cmd_addr,
    input  logic [7:0]              i_cmd_len,
    input  logic [7:0]              i_wdata,
    input  logic                    i_wdata_valid,
    output logic                    o_wdata_ready,
    output logic [FRAME_W-1:0]      o_frame,
    output logic                    o_frame_valid,
    input  logic                    i_frame_ready,
    input  logic                    i_abort,
    output logic                    o_rx_expect,
    output logic                    o_cmd_done,
    output logic                    o_cmd_err
);

    localparam int AW = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
    localparam logic [AW-1:0] ACNT_LAST = AW'(ADDR_BYTES - 1);
    localparam logic [1:0] AS = (ADDR_BYTES == 3) ? 2'b10 : 2'b01;

    state_t                  state_q, state_d;
    step_t                   step_q, step_d;
    cmd_op_t                 op_q, op_d;
    logic [3:0]              cs_q, cs_d;
    logic [8*ADDR_BYTES-1:0] addr_q, addr_d;
    logic [7:0]              len_q, len_d;
    logic [AW-1:0]           acnt_q, acnt_d;
    logic [8:0]              bcnt_q, bcnt_d;
    logic                    drain_q, drain_d;
    logic                    done_q, done_d;
    logic                    rx_q, rx_d;
    logic                    err_q, err_d;

    logic       ld_valid;
    logic [7:0] ld_byte;
    logic       ld_ready;
    logic       flush;
    logic [7:0] opcode;
    logic [7:0] addr_byte;

    assign addr_byte = 8'(addr_q >> {acnt_q, 3'b000});

    always_comb begin
        opcode = SYNCH;
        if (step_q == STEP_INC) begin
            opcode = ST_PTR_INC;
        end else begin
            case (op_q)
                OP_LDCS:  opcode = LDCS | {4'h0, cs_q};
                OP_STCS:  opcode = STCS | {4'h0, cs_q};
                OP_LDS:   opcode = LDS | {4'h0, AS, 2'b00};
                OP_STS:   opcode = STS | {4'h0, AS, 2'b00};
                OP_BURST: opcode = ST_PTR | {6'h0, AS};
                default:  opcode = SYNCH;
            endcase
        end
    end

    always_comb begin
        state_d       = state_q;
        step_d        = step_q;
        op_d          = op_q;
        cs_d          = cs_q;
        addr_d        = addr_q;
        len_d         = len_q;
        acnt_d        = acnt_q;
        bcnt_d        = bcnt_q;
        drain_d       = drain_q;
        done_d        = 1'b0;
        rx_d          = 1'b0;
        err_d         = 1'b0;
        ld_valid      = 1'b0;
        ld_byte       = SYNCH;
        flush         = 1'b0;
        o_wdata_ready = 1'b0;

        if (state_q == S_IDLE) begin
            // The leading SYNCH loads at capture so the first frame is valid next cycle.
            if (i_cmd_valid) begin
                if (i_cmd_op <= 3'd4) begin
                    op_d     = cmd_op_t'(i_cmd_op);
                    cs_d     = i_cmd_cs;
                    addr_d   = i_cmd_addr;
                    len_d    = i_cmd_len;
                    bcnt_d   = {1'b0, i_cmd_len} + 9'd1;
                    acnt_d   = '0;
                    step_d   = STEP_MAIN;
                    drain_d  = 1'b0;
                    ld_valid = 1'b1;
                    state_d  = S_OPCODE;
                end else begin
                    err_d = 1'b1;
                end
            end
        end else if (i_abort) begin
            flush   = 1'b1;
            drain_d = 1'b0;
            err_d   = 1'b1;
            state_d = S_IDLE;
        end else if (drain_q) begin
            // Last byte is loaded; finish once the serializer takes it.
            if (o_frame_valid && i_frame_ready) begin
                drain_d = 1'b0;
                done_d  = 1'b1;
                rx_d    = (op_q == OP_LDCS) || (op_q == OP_LDS);
                state_d = S_IDLE;
            end
        end else begin
            ld_valid = 1'b1;
            case (state_q)
                S_SYNC: begin
                    ld_byte = SYNCH;
                    if (ld_ready) state_d = (step_q == STEP_RPT) ? S_RPT_OP : S_OPCODE;
                end
                S_OPCODE: begin
                    ld_byte = opcode;
                    if (ld_ready) begin
                        if (step_q == STEP_INC || op_q == OP_STCS) state_d = S_DATA;
                        else if (op_q == OP_LDCS) drain_d = 1'b1;
                        else state_d = S_ADDR;
                    end
                end
                S_ADDR: begin
                    ld_byte = addr_byte;
                    if (ld_ready) begin
                        if (acnt_q != ACNT_LAST) begin
                            acnt_d = acnt_q + 1'b1;
                        end else if (op_q == OP_LDS) begin
                            drain_d = 1'b1;
                        end else if (op_q == OP_STS) begin
                            state_d = S_DATA;
                        end else begin
                            step_d  = STEP_RPT;
                            state_d = S_SYNC;
                        end
                    end
                end
                S_RPT_OP: begin
                    ld_byte = REPEAT;
                    if (ld_ready) state_d = S_RPT_CNT;
                end
                S_RPT_CNT: begin
                    ld_byte = len_q;
                    if (ld_ready) begin
                        step_d  = STEP_INC;
                        state_d = S_SYNC;
                    end
                end
                S_DATA: begin
                    ld_valid      = i_wdata_valid;
                    ld_byte       = i_wdata;
                    o_wdata_ready = ld_ready;
                    if (i_wdata_valid && ld_ready) begin
                        if (op_q != OP_BURST || bcnt_q == 9'd1) drain_d = 1'b1;
                        else bcnt_d = bcnt_q - 9'd1;
                    end
                end
                default: begin
                    ld_valid = 1'b0;
                    state_d  = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= S_IDLE;
            step_q  <= STEP_MAIN;
            op_q    <= OP_LDCS;
            cs_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            acnt_q  <= '0;
            bcnt_q  <= '0;
            drain_q <= 1'b0;
            done_q  <= 1'b0;
            rx_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            op_q    <= op_d;
            cs_q    <= cs_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            acnt_q  <= acnt_d;
            bcnt_q  <= bcnt_d;
            drain_q <= drain_d;
            done_q  <= done_d;
            rx_q    <= rx_d;
            err_q   <= err_d;
        end
    end

    updi_frame_reg #(
        .STOP_BITS (STOP_BITS),
        .FRAME_W   (FRAME_W)
    ) u_frame_reg (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_flush (flush),
        .i_valid (ld_valid),
        .i_byte  (ld_byte),
        .o_ready (ld_ready),
        .o_frame (o_frame),
        .o_valid (o_frame_valid),
        .i_ready (i_frame_ready)
    );

    assign o_cmd_ready = (state_q == S_IDLE);
    assign o_cmd_done  = done_q;
    assign o_rx_expect = rx_q;
    assign o_cmd_err   = err_q;

endmodule

// File: tb/tb_updi_cmd_gen.sv
// Randomized bench for updi_cmd_gen: a byte-list reference model of each UPDI
// command, checked per scenario; a second instance covers 3-byte addresses.
module tb_updi_cmd_gen;

    logic        i_clk;
    logic        i_rstn, rstn3;
    logic        i_cmd_valid, cmd_valid3;
    logic [2:0]  i_cmd_op;
    logic [3:0]  i_cmd_cs;
    logic [15:0] i_cmd_addr;
    logic [23:0] addr3;
    logic [7:0]  i_cmd_len, i_wdata;
    logic        i_wdata_valid, i_frame_ready, i_abort;

    logic        o_cmd_ready, o_wdata_ready, o_frame_valid, o_rx_expect, o_cmd_done, o_cmd_err;
    logic [11:0] o_frame;
    logic        cmd_ready3, wdata_ready3, frame_valid3, rx3, done3, err3;
    logic [10:0] frame3;

    int total = 0;
    int bad   = 0;

    logic [11:0] exp_q[$];
    logic [11:0] got_q[$];
    logic [7:0]  pay_q[$];
    logic [11:0] stall_q[$];
    logic        stall_fv_q[$];
    logic        stall_wr_q[$];
    int hs_cnt, done_gap, first_acc, last_acc, err_cnt, rx_stray;
    logic done_seen, rx_at_done, rdy_at_done;

    updi_cmd_gen dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_op(i_cmd_op), .i_cmd_cs(i_cmd_cs), .i_cmd_addr(i_cmd_addr), .i_cmd_len(i_cmd_len),
        .i_wdata(i_wdata), .i_wdata_valid(i_wdata_valid), .o_wdata_ready(o_wdata_ready),
        .o_frame(o_frame), .o_frame_valid(o_frame_valid), .i_frame_ready(i_frame_ready),
        .i_abort(i_abort), .o_rx_expect(o_rx_expect), .o_cmd_done(o_cmd_done), .o_cmd_err(o_cmd_err)
    );

    updi_cmd_gen #(.ADDR_BYTES(3), .STOP_BITS(1)) dut3 (
        .i_clk(i_clk), .i_rstn(rstn3), .i_cmd_valid(cmd_valid3), .o_cmd_ready(cmd_ready3),
        .i_cmd_op(i_cmd_op), .i_cmd_cs(i_cmd_cs), .i_cmd_addr(addr3), .i_cmd_len(i_cmd_len),
        .i_wdata(i_wdata), .i_wdata_valid(i_wdata_valid), .o_wdata_ready(wdata_ready3),
        .o_frame(frame3), .o_frame_valid(frame_valid3), .i_frame_ready(i_frame_ready),
        .i_abort(i_abort), .o_rx_expect(rx3), .o_cmd_done(done3), .o_cmd_err(err3)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Start bit at the top, then data, even parity, stop ones at the bottom.
    function automatic logic [11:0] mk_frame(input logic [7:0] b, input int stop);
        int p;
        p = $countones(b) % 2;
        if (stop == 2) return 12'((int'(b) << 3) + (p << 2) + 3);
        return 12'((int'(b) << 2) + (p << 1) + 1);
    endfunction

    // Byte list of a whole transaction, straight from the UPDI command formats.
    task automatic build_exp(input int op, input logic [3:0] cs, input logic [15:0] addr,
                             input logic [7:0] len);
        logic [7:0] bq[$];
        bq.push_back(8'h55);
        case (op)
            0: bq.push_back(8'h80 + 8'(cs));
            1: begin bq.push_back(8'hC0 + 8'(cs)); bq.push_back(pay_q[0]); end
            2: begin bq.push_back(8'h04); bq.push_back(addr[7:0]); bq.push_back(addr[15:8]); end
            3: begin
                bq.push_back(8'h44); bq.push_back(addr[7:0]); bq.push_back(addr[15:8]);
                bq.push_back(pay_q[0]);
            end
            default: begin
                bq.push_back(8'h69); bq.push_back(addr[7:0]); bq.push_back(addr[15:8]);
                bq.push_back(8'h55); bq.push_back(8'hA0); bq.push_back(len);
                bq.push_back(8'h55); bq.push_back(8'h64);
                for (int i = 0; i <= int'(len); i++) bq.push_back(pay_q[i]);
            end
        endcase
        exp_q.delete();
        foreach (bq[i]) exp_q.push_back(mk_frame(bq[i], 2));
    endtask

    // Runs one command on the default instance; records accepted frames and
    // handshake timing for the calling test to judge. Cycle 0 is the capture cycle.
    task automatic drive_cmd(input logic [2:0] op, input logic [3:0] cs, input logic [15:0] addr,
                             input logic [7:0] len, input int ready_pct, input int wvalid_pct,
                             input bit abort_first, input int stall_after, input int stall_cycles);
        int cyc, widx, stall_left;
        bit stalled;
        got_q.delete(); stall_q.delete(); stall_fv_q.delete(); stall_wr_q.delete();
        done_seen = 0; rx_at_done = 0; rdy_at_done = 0; done_gap = -1;
        first_acc = -1; last_acc = -1; err_cnt = 0; rx_stray = 0;
        widx = 0; stall_left = 0; stalled = 0;
        i_cmd_op = op; i_cmd_cs = cs; i_cmd_addr = addr; i_cmd_len = len;
        i_cmd_valid = 1'b1; i_abort = abort_first; i_frame_ready = 1'b1; i_wdata_valid = 1'b0;
        @(negedge i_clk);
        @(posedge i_clk); #1;
        i_cmd_valid = 1'b0; i_abort = 1'b0;
        cyc = 1;
        while (!done_seen && cyc < 2000) begin
            if (stall_after >= 0 && !stalled && got_q.size() == stall_after) begin
                stalled = 1; stall_left = stall_cycles;
            end
            if (stall_left > 0) i_frame_ready = 1'b0;
            else i_frame_ready = ($urandom_range(99) < ready_pct);
            i_wdata_valid = (widx < pay_q.size()) && ($urandom_range(99) < wvalid_pct);
            i_wdata = (widx < pay_q.size()) ? pay_q[widx] : 8'($urandom);
            @(negedge i_clk);
            if (stall_left > 0) begin
                stall_q.push_back(o_frame); stall_fv_q.push_back(o_frame_valid);
                stall_wr_q.push_back(o_wdata_ready);
                stall_left--;
            end
            if (o_cmd_err) err_cnt++;
            if (o_cmd_done) begin
                done_seen = 1; rx_at_done = o_rx_expect; rdy_at_done = o_cmd_ready;
                done_gap = cyc - last_acc;
            end else if (o_rx_expect) begin
                rx_stray++;
            end
            if (o_frame_valid && i_frame_ready) begin
                got_q.push_back(o_frame);
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
            end
            if (o_wdata_ready && i_wdata_valid) widx++;
            @(posedge i_clk); #1;
            cyc++;
        end
        hs_cnt = widx;
        i_frame_ready = 1'b0; i_wdata_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({o_cmd_ready, o_frame_valid, o_cmd_done, o_cmd_err, o_rx_expect, o_wdata_ready} !== 6'b100000) begin
            bad++; $display("FAIL reset_flags got=%b exp=100000",
                {o_cmd_ready, o_frame_valid, o_cmd_done, o_cmd_err, o_rx_expect, o_wdata_ready});
        end
        total++;
        if (o_frame !== 12'h000) begin bad++; $display("FAIL reset_frame got=%h exp=000", o_frame); end
        total++;
        if ({cmd_ready3, frame_valid3, frame3} !== {1'b1, 1'b0, 11'h000}) begin
            bad++; $display("FAIL reset_dut3 got=%b/%b/%h exp=1/0/000", cmd_ready3, frame_valid3, frame3);
        end
        repeat (2) @(posedge i_clk);
        #1; i_rstn = 1'b1; rstn3 = 1'b1;
        @(posedge i_clk); #1;
        @(negedge i_clk);
        total++;
        if ({o_cmd_ready, o_frame_valid, o_cmd_err} !== 3'b100) begin
            bad++; $display("FAIL idle_after_reset got=%b exp=100", {o_cmd_ready, o_frame_valid, o_cmd_err});
        end
        @(posedge i_clk); #1;
    endtask

    task automatic test_ldcs();
        logic [11:0] lit[2];
        lit[0] = 12'h2AB; lit[1] = 12'h45B;
        pay_q.delete();
        drive_cmd(3'd0, 4'hB, 16'h0000, 8'h00, 100, 100, 0, -1, 0);
        total++;
        if (got_q.size() != 2) begin bad++; $display("FAIL ldcs_count got=%0d exp=2", got_q.size()); end
        for (int i = 0; i < 2 && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== lit[i]) begin bad++; $display("FAIL ldcs_frame%0d got=%h exp=%h", i, got_q[i], lit[i]); end
        end
        total++;
        if ({done_seen, rx_at_done, rdy_at_done} !== 3'b111) begin
            bad++; $display("FAIL ldcs_done_rx got=%b exp=111", {done_seen, rx_at_done, rdy_at_done});
        end
        total++;
        if (done_gap != 1) begin bad++; $display("FAIL ldcs_done_gap got=%0d exp=1", done_gap); end
    endtask

    task automatic test_sts_stream();
        logic [11:0] lit[5];
        lit[0] = 12'h2AB; lit[1] = 12'h223; lit[2] = 12'h1A7; lit[3] = 12'h093; lit[4] = 12'h52B;
        pay_q.delete(); pay_q.push_back(8'hA5);
        drive_cmd(3'd3, 4'h0, 16'h1234, 8'h00, 100, 100, 0, -1, 0);
        total++;
        if (got_q.size() != 5) begin bad++; $display("FAIL sts_count got=%0d exp=5", got_q.size()); end
        for (int i = 0; i < 5 && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== lit[i]) begin bad++; $display("FAIL sts_frame%0d got=%h exp=%h", i, got_q[i], lit[i]); end
        end
        total++;
        if (first_acc != 1 || last_acc != 5) begin
            bad++; $display("FAIL sts_back_to_back got=%0d..%0d exp=1..5", first_acc, last_acc);
        end
        total++;
        if ({done_seen, rx_at_done, hs_cnt == 1, done_gap == 1} !== 4'b1011) begin
            bad++; $display("FAIL sts_done got=%b exp=1011", {done_seen, rx_at_done, hs_cnt == 1, done_gap == 1});
        end
    endtask

    task automatic test_burst(input int len);
        pay_q.delete();
        for (int i = 0; i <= len; i++) pay_q.push_back((len == 3) ? 8'(i + 1) : 8'($urandom));
        build_exp(4, 4'h0, 16'h1234, 8'(len));
        drive_cmd(3'd4, 4'h0, 16'h1234, 8'(len), (len == 3) ? 100 : 70, 80, 0, -1, 0);
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++; $display("FAIL burst%0d_count got=%0d exp=%0d", len, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL burst%0d_frame%0d got=%h exp=%h", len, i, got_q[i], exp_q[i]);
            end
        end
        total++;
        if (hs_cnt != len + 1) begin bad++; $display("FAIL burst%0d_wdata_hs got=%0d exp=%0d", len, hs_cnt, len + 1); end
        total++;
        if ({done_seen, rx_at_done, done_gap == 1} !== 3'b101) begin
            bad++; $display("FAIL burst%0d_done got=%b exp=101", len, {done_seen, rx_at_done, done_gap == 1});
        end
    endtask

    task automatic test_backpressure();
        pay_q.delete(); pay_q.push_back(8'h3C);
        build_exp(3, 4'h0, 16'h1234, 8'h00);
        drive_cmd(3'd3, 4'h0, 16'h1234, 8'h00, 100, 100, 0, 3, 5);
        total++;
        if (stall_q.size() != 5) begin bad++; $display("FAIL bp_stall_len got=%0d exp=5", stall_q.size()); end
        foreach (stall_q[i]) begin
            total++;
            if ({stall_fv_q[i], stall_wr_q[i], stall_q[i]} !== {1'b1, 1'b0, exp_q[3]}) begin
                bad++; $display("FAIL bp_hold%0d got=%b/%b/%h exp=1/0/%h", i, stall_fv_q[i], stall_wr_q[i], stall_q[i], exp_q[3]);
            end
        end
        total++;
        if (got_q != exp_q) begin bad++; $display("FAIL bp_frames got=%p exp=%p", got_q, exp_q); end
        total++;
        if (done_seen !== 1'b1 || hs_cnt != 1) begin bad++; $display("FAIL bp_done got=%b/%0d exp=1/1", done_seen, hs_cnt); end
    endtask

    task automatic test_illegal();
        for (int op = 5; op <= 7; op++) begin
            int fv, errs, err_at;
            fv = 0; errs = 0; err_at = -1;
            i_cmd_op = 3'(op); i_cmd_valid = 1'b1; i_frame_ready = 1'b1;
            @(posedge i_clk); #1;
            i_cmd_valid = 1'b0;
            for (int c = 1; c <= 4; c++) begin
                @(negedge i_clk);
                if (o_frame_valid) fv++;
                if (o_cmd_err) begin errs++; if (err_at < 0) err_at = c; end
                total++;
                if (o_cmd_ready !== 1'b1) begin bad++; $display("FAIL illegal%0d_ready got=%b exp=1", op, o_cmd_ready); end
                @(posedge i_clk); #1;
            end
            total++;
            if (fv != 0 || errs != 1 || err_at != 1) begin
                bad++; $display("FAIL illegal%0d got=fv%0d err%0d@%0d exp=fv0 err1@1", op, fv, errs, err_at);
            end
        end
        i_frame_ready = 1'b0;
    endtask

    task automatic test_abort();
        int widx, guard, extra;
        pay_q.delete();
        for (int i = 0; i < 8; i++) pay_q.push_back(8'($urandom));
        build_exp(4, 4'h0, 16'h1234, 8'd7);
        got_q.delete();
        widx = 0; guard = 0; extra = 0;
        i_cmd_op = 3'd4; i_cmd_addr = 16'h1234; i_cmd_len = 8'd7; i_cmd_valid = 1'b1; i_frame_ready = 1'b1;
        @(posedge i_clk); #1;
        i_cmd_valid = 1'b0;
        while (i_abort == 1'b0 && guard < 100) begin
            i_abort = (widx == 1);
            i_wdata_valid = 1'b1; i_wdata = pay_q[widx];
            @(negedge i_clk);
            if (o_frame_valid && i_frame_ready) got_q.push_back(o_frame);
            if (o_wdata_ready && i_wdata_valid) widx++;
            @(posedge i_clk); #1;
            guard++;
        end
        i_abort = 1'b0; i_wdata_valid = 1'b0;
        @(negedge i_clk);
        total++;
        if ({o_frame_valid, o_cmd_err, o_cmd_ready, o_cmd_done} !== 4'b0110) begin
            bad++; $display("FAIL abort_next got=%b exp=0110", {o_frame_valid, o_cmd_err, o_cmd_ready, o_cmd_done});
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge i_clk); #1;
            @(negedge i_clk);
            if (o_cmd_err || o_cmd_done || o_frame_valid) extra++;
        end
        total++;
        if (extra != 0) begin bad++; $display("FAIL abort_quiet got=%0d exp=0", extra); end
        total++;
        if (got_q.size() != 10) begin bad++; $display("FAIL abort_prefix_len got=%0d exp=10", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 10; i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL abort_prefix%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        @(posedge i_clk); #1;
        pay_q.delete();
        drive_cmd(3'd0, 4'h2, 16'h0000, 8'h00, 100, 100, 0, -1, 0);
        total++;
        if (got_q.size() != 2 || got_q[1] !== mk_frame(8'h82, 2) || done_seen !== 1'b1) begin
            bad++; $display("FAIL abort_recover got=%0d frames done=%b exp=2 frames done=1", got_q.size(), done_seen);
        end
    endtask

    task automatic test_abort_with_cmd();
        logic [15:0] a;
        a = 16'($urandom);
        pay_q.delete();
        build_exp(2, 4'h0, a, 8'h00);
        drive_cmd(3'd2, 4'h0, a, 8'h00, 60, 100, 1, -1, 0);
        total++;
        if (got_q != exp_q || err_cnt != 0 || done_seen !== 1'b1 || rx_at_done !== 1'b1) begin
            bad++; $display("FAIL idle_abort_cmd got=%p err=%0d done=%b exp=%p err=0 done=1", got_q, err_cnt, done_seen, exp_q);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            int op, len, nd;
            logic [3:0] cs;
            logic [15:0] a;
            op = $urandom_range(4); cs = 4'($urandom); a = 16'($urandom); len = $urandom_range(15);
            nd = (op == 1 || op == 3) ? 1 : (op == 4) ? len + 1 : 0;
            pay_q.delete();
            for (int i = 0; i < nd; i++) pay_q.push_back(8'($urandom));
            build_exp(op, cs, a, 8'(len));
            drive_cmd(3'(op), cs, a, 8'(len), $urandom_range(40, 100), $urandom_range(40, 100), 0, -1, 0);
            total++;
            if (got_q != exp_q) begin bad++; $display("FAIL rand%0d_frames op=%0d got=%p exp=%p", n, op, got_q, exp_q); end
            total++;
            if ({done_seen, rx_at_done, done_gap == 1, hs_cnt == nd, err_cnt == 0, rx_stray == 0}
                !== {1'b1, (op == 0 || op == 2), 4'b1111}) begin
                bad++; $display("FAIL rand%0d_ctrl op=%0d got=%b%b gap=%0d hs=%0d err=%0d exp rx=%0d hs=%0d",
                    n, op, done_seen, rx_at_done, done_gap, hs_cnt, err_cnt, (op == 0 || op == 2), nd);
            end
        end
    endtask

    task automatic test_dut3_lds();
        logic [7:0]  bl[5];
        logic [10:0] got3[$];
        int guard;
        logic seen;
        bl[0] = 8'h55; bl[1] = 8'h08; bl[2] = 8'h45; bl[3] = 8'h23; bl[4] = 8'h01;
        i_cmd_op = 3'd2; addr3 = 24'h012345; cmd_valid3 = 1'b1; i_frame_ready = 1'b1;
        @(posedge i_clk); #1;
        cmd_valid3 = 1'b0;
        guard = 0; seen = 0;
        while (!seen && guard < 30) begin
            @(negedge i_clk);
            if (frame_valid3 && i_frame_ready) got3.push_back(frame3);
            if (done3) seen = rx3;
            @(posedge i_clk); #1;
            guard++;
        end
        total++;
        if (got3.size() != 5 || seen !== 1'b1) begin
            bad++; $display("FAIL lds3_count got=%0d rx_done=%b exp=5 rx_done=1", got3.size(), seen);
        end
        for (int i = 0; i < 5 && i < got3.size(); i++) begin
            total++;
            if (got3[i] !== 11'(mk_frame(bl[i], 1))) begin
                bad++; $display("FAIL lds3_frame%0d got=%h exp=%h", i, got3[i], 11'(mk_frame(bl[i], 1)));
            end
        end
    endtask

    task automatic test_dut3_reset();
        int stray;
        stray = 0;
        i_cmd_op = 3'd2; addr3 = 24'hABCDEF; cmd_valid3 = 1'b1; i_frame_ready = 1'b1;
        @(posedge i_clk); #1;
        cmd_valid3 = 1'b0;
        @(posedge i_clk); #2;
        rstn3 = 1'b0;
        #1;
        total++;
        if ({frame_valid3, cmd_ready3, done3, err3, rx3, wdata_ready3, frame3} !== {6'b010000, 11'h000}) begin
            bad++; $display("FAIL rst3_async got=%b/%h exp=010000/000",
                {frame_valid3, cmd_ready3, done3, err3, rx3, wdata_ready3}, frame3);
        end
        @(negedge i_clk); #2;
        rstn3 = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge i_clk);
            if (done3 || err3 || frame_valid3 || !cmd_ready3) stray++;
        end
        total++;
        if (stray != 0) begin bad++; $display("FAIL rst3_quiet got=%0d exp=0", stray); end
        @(posedge i_clk); #1;
        i_frame_ready = 1'b0;
    endtask

    initial begin
        i_rstn = 1'b0; rstn3 = 1'b0; i_cmd_valid = 1'b0; cmd_valid3 = 1'b0;
        i_cmd_op = '0; i_cmd_cs = '0; i_cmd_addr = '0; addr3 = '0; i_cmd_len = '0;
        i_wdata = '0; i_wdata_valid = 1'b0; i_frame_ready = 1'b0; i_abort = 1'b0;
        test_reset();
        test_ldcs();
        test_sts_stream();
        test_burst(3);
        test_burst(0);
        test_burst(255);
        test_backpressure();
        test_illegal();
        test_abort();
        test_abort_with_cmd();
        test_random();
        test_dut3_lds();
        test_dut3_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
